// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg -- shared definitions for the control-signal pipeline.
// Stage index names and the control-word bit layout live here, so the
// main decoder and the pipeline agree on where each field sits.
package ctrl_pipe_pkg;

  // Stage indices after Decode
  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  // Control-word bit fields
  localparam int CTRL_MC         = 0;  // multi-cycle op (div/mult)
  localparam int CTRL_MEMTOREG   = 1;
  localparam int CTRL_MEMWRITE   = 2;
  localparam int CTRL_REGWRITE   = 3;
  localparam int CTRL_WRITE_HILO = 4;
  localparam int CTRL_ALUOP_LSB  = 5;
  localparam int CTRL_ALUOP_W    = 4;

  // Width of the multi-cycle hold counter. A 1-cycle op never holds, but
  // the counter still needs at least one bit to exist.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/ctrl_stage.sv
// ctrl_stage -- one pipeline register for a control word plus its valid bit.
// Update priority: flush > hold > bubble > load. An invalid stage always
// carries an all-zero control word.
//   clk, rst   clock, asynchronous active-low reset
//   flush      clear this stage
//   hold       keep the current contents
//   bubble     load an empty slot (valid=0, ctrl=0)
//   in_valid   valid bit of the upstream stage
//   in_ctrl    control word of the upstream stage
//   q_valid    registered valid
//   q_ctrl     registered control word
module ctrl_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic         bubble,
  input  logic         in_valid,
  input  logic [W-1:0] in_ctrl,
  output logic         q_valid,
  output logic [W-1:0] q_ctrl
);

  // NOTE: state registers use non-blocking assignments and are cleared by the
  // asynchronous reset; a blocking assignment here would let a downstream
  // stage see this stage's new value within the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (hold) begin
      q_valid <= q_valid;
      q_ctrl  <= q_ctrl;
    end else if (bubble) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else begin
      q_valid <= in_valid;
      q_ctrl  <= in_valid ? in_ctrl : '0;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- carries the decoded control word from Decode through STAGES
// downstream stages (index 0 = Execute). Stalls propagate backward, a bubble
// is placed in front of the oldest stalled stage, and a hold counter keeps a
// multi-cycle op in Execute for MC_CYCLES cycles.
//   clk, rst    clock, asynchronous active-low reset
//   d_valid     Decode holds a valid instruction
//   d_ctrl      control word from the main decoder
//   stall_in    external stall request per stage
//   flush_in    flush request per stage
//   q_ctrl      control word per stage, stage k at [k*W +: W]
//   q_valid     valid per stage
//   stall_eff   effective stall per stage (propagated + multi-cycle hold)
//   d_stall     Decode must hold (= stall_eff[0])
//   mc_busy     multi-cycle hold in progress
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int W         = 32,
  parameter int STAGES    = 3,
  parameter int MC_BIT    = CTRL_MC,
  parameter int MC_CYCLES = 36
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_valid,
  input  logic [W-1:0]        d_ctrl,
  input  logic [STAGES-1:0]   stall_in,
  input  logic [STAGES-1:0]   flush_in,
  output logic [STAGES*W-1:0] q_ctrl,
  output logic [STAGES-1:0]   q_valid,
  output logic [STAGES-1:0]   stall_eff,
  output logic                d_stall,
  output logic                mc_busy
);

  localparam int            CW       = cnt_width(MC_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_CYCLES - 1);

  logic [CW-1:0]     cnt;
  logic [STAGES-1:0] ext_stall;
  logic              mc_load;

  // A stall anywhere downstream stalls every older stage. Walk from the
  // last stage toward Execute accumulating the requests.
  // NOTE: every always_comb output gets a default before the loop, so no
  // path through the block leaves a bit unassigned and no latch is inferred.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    ext_stall = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc          = acc | stall_in[k];
      ext_stall[k] = acc;
    end
  end

  assign mc_busy   = (cnt != '0);
  assign stall_eff = ext_stall | STAGES'(mc_busy);
  assign d_stall   = stall_eff[0];

  // Only a fresh load into Execute arms the counter; a held word never
  // re-arms it, and the counter cannot be loaded while it is still running
  // because mc_busy itself stalls Execute.
  assign mc_load = d_valid & d_ctrl[MC_BIT] & ~stall_eff[0] & (MC_CYCLES > 1);

  // Counts down regardless of external stalls; a stage-0 flush aborts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (flush_in[0]) begin
      cnt <= '0;
    end else if (mc_load) begin
      cnt <= CNT_LOAD;
    end else if (mc_busy) begin
      cnt <= cnt - CW'(1);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic         in_valid;
    logic [W-1:0] in_ctrl;
    logic         bubble;

    // The bubble condition is "my source is stalled". For Execute the source
    // is Decode, whose hold equals stall_eff[0], which also holds Execute, so
    // the bubble path is only reachable for the later stages.
    if (k == 0) begin : g_head
      assign in_valid = d_valid;
      assign in_ctrl  = d_ctrl;
      assign bubble   = stall_eff[0];
    end else begin : g_body
      assign in_valid = q_valid[k-1];
      assign in_ctrl  = q_ctrl[(k-1)*W +: W];
      assign bubble   = stall_eff[k-1];
    end

    ctrl_stage #(.W(W)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_in[k]),
      .hold     (stall_eff[k]),
      .bubble   (bubble),
      .in_valid (in_valid),
      .in_ctrl  (in_ctrl),
      .q_valid  (q_valid[k]),
      .q_ctrl   (q_ctrl[k*W +: W])
    );
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe -- self-checking bench for ctrl_pipe.
// Two instances run side by side on one clock:
//   dut a: W=32, STAGES=3, MC_BIT=0, MC_CYCLES=4  (directed + random)
//   dut b: W=8,  STAGES=5, MC_BIT=2, MC_CYCLES=1  (wide pipe, no-hold case)
// A behavioural model tracks each pipe as plain arrays; the multi-cycle hold
// is modelled by how long the op has been sitting in Execute.
module tb_ctrl_pipe;

  logic clk;
  logic rst;

  logic        dv_a;
  logic [31:0] dc_a;
  logic [2:0]  si_a, fi_a;
  logic [95:0] qc_a;
  logic [2:0]  qv_a, se_a;
  logic        ds_a, mb_a;

  logic        dv_b;
  logic [7:0]  dc_b;
  logic [4:0]  si_b, fi_b;
  logic [39:0] qc_b;
  logic [4:0]  qv_b, se_b;
  logic        ds_b, mb_b;

  ctrl_pipe #(.W(32), .STAGES(3), .MC_BIT(0), .MC_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .d_valid(dv_a), .d_ctrl(dc_a),
    .stall_in(si_a), .flush_in(fi_a), .q_ctrl(qc_a), .q_valid(qv_a),
    .stall_eff(se_a), .d_stall(ds_a), .mc_busy(mb_a)
  );

  ctrl_pipe #(.W(8), .STAGES(5), .MC_BIT(2), .MC_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .d_valid(dv_b), .d_ctrl(dc_b),
    .stall_in(si_b), .flush_in(fi_b), .q_ctrl(qc_b), .q_valid(qv_b),
    .stall_eff(se_b), .d_stall(ds_b), .mc_busy(mb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          n_stg[2];
  int          m_cyc[2];
  int          m_bit[2];
  logic        m_v[2][8];
  logic [31:0] m_c[2][8];
  int          m_age[2];   // cycles the Execute word has already been held

  task automatic model_reset(input int id);
    for (int k = 0; k < 8; k++) begin
      m_v[id][k] = 1'b0;
      m_c[id][k] = '0;
    end
    m_age[id] = 0;
  endtask

  // A multi-cycle op occupies Execute for m_cyc cycles in total, so it keeps
  // Execute busy while it has been there fewer than m_cyc-1 extra cycles.
  function automatic logic model_busy(input int id);
    logic [31:0] w;
    w = m_c[id][0];
    return m_v[id][0] && w[m_bit[id]] && (m_cyc[id] > 1) && (m_age[id] < m_cyc[id] - 1);
  endfunction

  function automatic logic [7:0] model_se(input int id, input logic [7:0] si);
    logic [7:0] se;
    se = '0;
    for (int k = 0; k < n_stg[id]; k++) se[k] = |(si >> k);
    se[0] = se[0] | model_busy(id);
    return se;
  endfunction

  task automatic model_step(input int id, input logic dv, input logic [31:0] dc,
                            input logic [7:0] si, input logic [7:0] fi);
    logic [7:0]  se;
    logic        nv[8];
    logic [31:0] nc[8];
    se = model_se(id, si);
    for (int k = 0; k < 8; k++) begin
      nv[k] = m_v[id][k];
      nc[k] = m_c[id][k];
    end
    for (int k = 0; k < n_stg[id]; k++) begin
      if (fi[k]) begin
        nv[k] = 1'b0; nc[k] = '0;
      end else if (se[k]) begin
        nv[k] = m_v[id][k]; nc[k] = m_c[id][k];
      end else if (k == 0) begin
        nv[k] = dv; nc[k] = dv ? dc : '0;
      end else if (se[k-1]) begin
        nv[k] = 1'b0; nc[k] = '0;
      end else begin
        nv[k] = m_v[id][k-1]; nc[k] = m_c[id][k-1];
      end
    end
    m_age[id] = (fi[0] || !se[0]) ? 0 : m_age[id] + 1;
    for (int k = 0; k < 8; k++) begin
      m_v[id][k] = nv[k];
      m_c[id][k] = nc[k];
    end
  endtask

  task automatic check_dut(input int id);
    logic [7:0]  si, exp_se, exp_qv, got_qv, got_se;
    logic        got_ds, got_mb;
    logic [31:0] got_c;
    string       p;
    if (id == 0) begin
      p = "a"; si = 8'(si_a); got_qv = 8'(qv_a); got_se = 8'(se_a);
      got_ds = ds_a; got_mb = mb_a;
    end else begin
      p = "b"; si = 8'(si_b); got_qv = 8'(qv_b); got_se = 8'(se_b);
      got_ds = ds_b; got_mb = mb_b;
    end
    exp_se = model_se(id, si);
    exp_qv = '0;
    for (int k = 0; k < n_stg[id]; k++) exp_qv[k] = m_v[id][k];
    check({p, ".q_valid"},   64'(got_qv), 64'(exp_qv));
    check({p, ".stall_eff"}, 64'(got_se), 64'(exp_se));
    check({p, ".d_stall"},   64'(got_ds), 64'(exp_se[0]));
    check({p, ".mc_busy"},   64'(got_mb), 64'(model_busy(id)));
    for (int k = 0; k < n_stg[id]; k++) begin
      if (id == 0) got_c = qc_a[k*32 +: 32];
      else         got_c = 32'(qc_b[k*8 +: 8]);
      check($sformatf("%s.q_ctrl[%0d]", p, k), 64'(got_c), 64'(m_c[id][k]));
    end
  endtask

  // Called at a falling edge with inputs already driven: check the current
  // outputs against the model, then advance both through one rising edge.
  task automatic step();
    #1;
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    if (!rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, dv_a, dc_a, 8'(si_a), 8'(fi_a));
      model_step(1, dv_b, 32'(dc_b), 8'(si_b), 8'(fi_b));
    end
    @(negedge clk);
  endtask

  task automatic rand_b();
    dv_b = ($urandom_range(0, 3) != 0);
    dc_b = 8'($urandom);
    for (int k = 0; k < 5; k++) begin
      si_b[k] = ($urandom_range(0, 5) == 0);
      fi_b[k] = ($urandom_range(0, 11) == 0);
    end
  endtask

  task automatic rand_a();
    dv_a = ($urandom_range(0, 3) != 0);
    dc_a = $urandom;
    for (int k = 0; k < 3; k++) begin
      si_a[k] = ($urandom_range(0, 5) == 0);
      fi_a[k] = ($urandom_range(0, 11) == 0);
    end
  endtask

  task automatic cyc();
    rand_b();
    step();
  endtask

  task automatic drain_a(input int n);
    dv_a = 1'b0; dc_a = '0; si_a = '0; fi_a = '0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] words[4];
    logic [31:0] got_w[$];
    logic [7:0]  sev;
    logic        acc;
    int          idx, ds_cnt, e_cnt, b_cnt;

    n_stg[0] = 3; m_cyc[0] = 4; m_bit[0] = 0;
    n_stg[1] = 5; m_cyc[1] = 1; m_bit[1] = 2;
    model_reset(0);
    model_reset(1);

    rst  = 1'b0;
    dv_a = 1'b0; dc_a = '0; si_a = '0; fi_a = '0;
    dv_b = 1'b0; dc_b = '0; si_b = '0; fi_b = '0;
    @(negedge clk);

    // Reset and basic flow: words presented during reset go nowhere.
    dv_a = 1'b1; dc_a = 32'hA4;
    step();
    step();
    rst = 1'b1;
    cyc();
    check("flow.e_after_1", 64'(qc_a[31:0]), 64'h A4);
    cyc();
    check("flow.m_after_2", 64'(qc_a[63:32]), 64'h A4);
    cyc();
    check("flow.w_after_3", 64'(qc_a[95:64]), 64'h A4);
    check("flow.all_valid", 64'(qv_a), 64'h7);

    // Wide pipe: 5-stage latency and per-stage slicing. The op flag bit is
    // set in A5 but a 1-cycle op must not hold anything.
    dv_b = 1'b0; dc_b = '0; si_b = '0; fi_b = '0;
    dv_a = 1'b0; si_a = '0; fi_a = '0;
    for (int i = 0; i < 5; i++) step();
    dv_b = 1'b1; dc_b = 8'hA5;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("wide.valid_%0d", i), 64'(qv_b), 64'((1 << i) - 1));
      check($sformatf("wide.slice_%0d", i - 1), 64'(qc_b[(i-1)*8 +: 8]), 64'hA5);
    end
    check("wide.no_hold", 64'(mb_b), 64'h0);

    // Back-propagated stall on M for two cycles while 2,4,6,8 stream in.
    drain_a(3);
    words = '{32'd2, 32'd4, 32'd6, 32'd8};
    idx = 0; ds_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      if (idx < 4) begin dv_a = 1'b1; dc_a = words[idx]; end
      else         begin dv_a = 1'b0; dc_a = '0; end
      si_a = (c == 2 || c == 3) ? 3'b010 : 3'b000;
      fi_a = '0;
      rand_b();
      sev = model_se(0, 8'(si_a));
      acc = dv_a && !sev[0];
      #1;
      if (ds_a) ds_cnt++;
      step();
      if (acc) idx++;
      if (qv_a[2]) got_w.push_back(qc_a[95:64]);
    end
    check("stall.d_stall_cycles", 64'(ds_cnt), 64'd2);
    check("stall.w_count", 64'(got_w.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_w.size(); i++)
      check($sformatf("stall.w_word_%0d", i), 64'(got_w[i]), 64'(words[i]));

    // Multi-cycle op: 4 cycles in Execute, busy for 3.
    drain_a(3);
    dv_a = 1'b1; dc_a = 32'h11;
    cyc();
    dv_a = 1'b0; dc_a = '0;
    e_cnt = 0; b_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (qv_a[0] && qc_a[31:0] == 32'h11) e_cnt++;
      if (mb_a) b_cnt++;
      if (i < 8) cyc();
    end
    check("mc.e_cycles", 64'(e_cnt), 64'd4);
    check("mc.busy_cycles", 64'(b_cnt), 64'd3);

    // Flush beats stall on Execute during a hold and aborts it.
    drain_a(3);
    dv_a = 1'b1; dc_a = 32'h11;
    cyc();
    dv_a = 1'b0; dc_a = '0;
    cyc();
    si_a = 3'b001; fi_a = 3'b001;
    cyc();
    si_a = '0; fi_a = '0;
    #1;
    check("flush.mc_busy", 64'(mb_a), 64'h0);
    check("flush.e_valid", 64'(qv_a[0]), 64'h0);
    check("flush.d_stall", 64'(ds_a), 64'h0);
    #1;
    cyc();

    // Asynchronous reset between edges in the middle of a hold.
    dv_a = 1'b1; dc_a = 32'h11;
    cyc();
    dv_a = 1'b0; dc_a = '0;
    cyc();
    check("areset.hold_active", 64'(mb_a), 64'h1);
    dv_b = 1'b0; dc_b = '0; si_b = '0; fi_b = '0;
    #1 rst = 1'b0;
    #1;
    check("areset.a_valid", 64'(qv_a), 64'h0);
    check("areset.a_ctrl_any", 64'(|qc_a), 64'h0);
    check("areset.a_busy", 64'(mb_a), 64'h0);
    check("areset.a_d_stall", 64'(ds_a), 64'h0);
    check("areset.b_valid", 64'(qv_b), 64'h0);
    check("areset.b_ctrl_any", 64'(|qc_b), 64'h0);
    model_reset(0);
    model_reset(1);
    step();
    rst = 1'b1;

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      rand_a();
      rand_b();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
